// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin write arbiter for one shared WIDTH-bit register
// shared by four requesters.
// Latency: req sampled at E0 -> gnt in E0..E1 -> q updated at E1 (2 edges).
// Backpressure: one grant per 2 cycles; a requester holds req/wdata until it sees gnt.
//   An abort (req dropped during GRANT) discards the write.
// Config macro: DFF_WRITE_ARB_FIXED_PRIO_EN. When it is defined, the arbiter uses
//   fixed priority (req[0] highest) and has no rotation pointer.
// Ports:
//   clk, reset (sync, active-high), req[3:0], wdata[4*WIDTH-1:0] (requester i at [i*WIDTH +: WIDTH])
//   gnt[3:0] one-hot registered grant, owner[1:0] current/last grantee, busy (GRANT state)
//   q[WIDTH-1:0] shared register, q_valid one-cycle write pulse, wr_count[7:0] completed writes
module dff_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic [7:0]         wr_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             q_valid_q, q_valid_d;
  logic [7:0]       wr_count_q, wr_count_d;
  logic [1:0]       winner;
  logic [WIDTH-1:0] wdata_arr [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

`ifdef DFF_WRITE_ARB_FIXED_PRIO_EN
  // Lowest index wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic       found;
  logic [1:0] idx;

  // Search starts at ptr and wraps mod 4 through the 2-bit add.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    data_d     = data_q;
    q_valid_d  = 1'b0;
    wr_count_d = wr_count_q;
`ifndef DFF_WRITE_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (|req) begin
          gnt_d          = 4'b0000;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          busy_d         = 1'b1;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        // Requester still asserting req means the write completes; else abort.
        if (req[owner_q]) begin
          data_d     = wdata_arr[owner_q];
          q_valid_d  = 1'b1;
          wr_count_d = wr_count_q + 8'd1;
        end
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifndef DFF_WRITE_ARB_FIXED_PRIO_EN
        ptr_d   = owner_q + 2'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      owner_q    <= 2'd0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      q_valid_q  <= 1'b0;
      wr_count_q <= 8'd0;
`ifndef DFF_WRITE_ARB_FIXED_PRIO_EN
      ptr_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      q_valid_q  <= q_valid_d;
      wr_count_q <= wr_count_d;
`ifndef DFF_WRITE_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign q        = data_q;
  assign q_valid  = q_valid_q;
  assign wr_count = wr_count_q;

endmodule
